// File: rtl/axi_mem_responder.sv
// AXI4 slave endpoint backed by a 64-bit byte-writable memory. Independent read and
// write FSMs, one outstanding transaction each, FIXED/INCR bursts only.
module axi_mem_responder #(
  parameter int TAG_W  = 3,
  parameter int ADDR_W = 10
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             awvalid,
  output logic             awready,
  input  logic [TAG_W-1:0] awid,
  input  logic [31:0]      awaddr,
  input  logic [7:0]       awlen,
  input  logic [2:0]       awsize,
  input  logic [1:0]       awburst,
  input  logic             wvalid,
  output logic             wready,
  input  logic [63:0]      wdata,
  input  logic [7:0]       wstrb,
  input  logic             wlast,
  output logic             bvalid,
  input  logic             bready,
  output logic [TAG_W-1:0] bid,
  output logic [1:0]       bresp,
  input  logic             arvalid,
  output logic             arready,
  input  logic [TAG_W-1:0] arid,
  input  logic [31:0]      araddr,
  input  logic [7:0]       arlen,
  input  logic [2:0]       arsize,
  input  logic [1:0]       arburst,
  output logic             rvalid,
  input  logic             rready,
  output logic [TAG_W-1:0] rid,
  output logic [63:0]      rdata,
  output logic [1:0]       rresp,
  output logic             rlast
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Only FIXED/INCR with at most 8 bytes per beat fit the 64-bit memory.
  function automatic logic bad_req(input logic [1:0] burst, input logic [2:0] size);
    return (burst > 2'b01) || (size > 3'd3);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    logic [31:0] sb;
    sb = 32'd1 << size;
    if (burst == 2'b01) return (a & ~(sb - 32'd1)) + sb;
    return a;
  endfunction

  logic [63:0] mem [0:(1<<ADDR_W)-1];

  w_state_e          w_state, w_state_nxt;
  logic [TAG_W-1:0]  w_id;
  logic [31:0]       w_addr;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err;
  logic              aw_hs, w_hs, b_hs, w_last_beat;
  logic [ADDR_W-1:0] w_idx;

  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign b_hs        = bvalid & bready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_idx       = w_addr[ADDR_W+2:3];
  assign bid         = bvalid ? w_id : '0;
  assign bresp       = {bvalid & w_err, 1'b0};

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  // The FSM leaves W_DATA on the len-th beat whatever wlast says.
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      awready <= (w_state_nxt == W_IDLE);
      wready  <= (w_state_nxt == W_DATA);
      bvalid  <= (w_state_nxt == W_RESP);
      if (aw_hs) begin
        w_id    <= awid;
        w_addr  <= awaddr;
        w_len   <= awlen;
        w_size  <= awsize;
        w_burst <= awburst;
        w_cnt   <= '0;
        w_err   <= bad_req(awburst, awsize);
      end else if (w_hs) begin
        w_cnt  <= w_cnt + 8'd1;
        w_addr <= next_addr(w_addr, w_size, w_burst);
        if (wlast != w_last_beat) w_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_err) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  r_state_e          r_state, r_state_nxt;
  logic [31:0]       r_addr, r_addr_nxt;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_err, ar_err, ar_hs, r_hs;
  logic [ADDR_W-1:0] ar_idx, r_nxt_idx;

  assign ar_hs      = arvalid & arready;
  assign r_hs       = rvalid & rready;
  assign ar_err     = bad_req(arburst, arsize);
  assign r_addr_nxt = next_addr(r_addr, r_size, r_burst);
  assign ar_idx     = araddr[ADDR_W+2:3];
  assign r_nxt_idx  = r_addr_nxt[ADDR_W+2:3];
  assign rresp      = {rvalid & r_err, 1'b0};

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && rlast) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // rdata is prefetched into the output register, so a same-cycle write sees old data.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rlast   <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
    end else begin
      arready <= (r_state_nxt == R_IDLE);
      rvalid  <= (r_state_nxt == R_DATA);
      if (ar_hs) begin
        rid     <= arid;
        r_addr  <= araddr;
        r_len   <= arlen;
        r_size  <= arsize;
        r_burst <= arburst;
        r_cnt   <= '0;
        r_err   <= ar_err;
        rlast   <= (arlen == 8'd0);
        rdata   <= ar_err ? 64'd0 : mem[ar_idx];
      end else if (r_hs) begin
        if (rlast) begin
          rlast <= 1'b0;
        end else begin
          r_addr <= r_addr_nxt;
          r_cnt  <= r_cnt + 8'd1;
          rlast  <= ((r_cnt + 8'd1) == r_len);
          rdata  <= r_err ? 64'd0 : mem[r_nxt_idx];
        end
      end
    end
  end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 slave endpoint that terminates one LSU-side AXI port from the interconnect; instantiated behind either the default or the bridge-range slave port.
- Backs the port with an internal 64-bit-wide byte-writable memory.
- Read and write channels are handled by independent state machines; one outstanding transaction per direction.
- Supports FIXED and INCR bursts; all other cases return SLVERR.

Parameters:
- TAG_W, 3, AXI ID width; set equal to pt.LSU_BUS_TAG at instantiation.
- ADDR_W, 10, log2 of memory depth in 64-bit words; index = addr[ADDR_W+2:3].

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- awvalid, awready  in, out  1  AW handshake
- awid  in  TAG_W  write ID
- awaddr  in  32  write start byte address
- awlen  in  8  beats-1
- awsize  in  3  bytes/beat = 1<<awsize
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- wvalid, wready  in, out  1  W handshake
- wdata  in  64  write data
- wstrb  in  8  byte enables
- wlast  in  1  last beat
- bvalid, bready  out, in  1  B handshake
- bid  out  TAG_W  echoed awid
- bresp  out  2  00 OKAY, 10 SLVERR
- arvalid, arready  in, out  1  AR handshake
- arid  in  TAG_W
- araddr  in  32
- arlen  in  8
- arsize  in  3
- arburst  in  2
- rvalid, rready  out, in  1  R handshake
- rid  out  TAG_W
- rdata  out  64
- rresp  out  2
- rlast  out  1
- region/lock/cache/prot/qos are not ported; the interconnect outputs for these are left open.

Behaviour:
- Reset (rst_l=0, async): all outputs 0, both FSMs to IDLE. Memory contents are not reset.
- Ready after reset: awready and arready are registered and rise on the first clk edge after rst_l deasserts.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On awvalid&awready, capture id, addr, len, size, burst; clear beat_cnt and err; go to W_DATA and drop awready.
  - Error on AW accept: err is set if awburst is not FIXED/INCR or awsize>3.
  - W_DATA: wready=1. Each wvalid&wready beat writes wdata bytes where wstrb=1 to mem[idx], only if err=0.
  - Address update per beat (INCR): addr = (addr & ~(size_bytes-1)) + size_bytes. FIXED holds addr.
  - Address wrap and aliasing: the index wraps modulo 2^ADDR_W. Address bits above ADDR_W+2 are ignored, so the memory aliases.
  - Byte lanes are not masked by size; the strobe alone is authoritative.
  - Beat count check: wlast must equal (beat_cnt==len), else err is set. The FSM leaves W_DATA on the beat where beat_cnt==len, regardless of wlast.
  - W_RESP: bvalid=1, bid=captured id, bresp=err?10:00. On bready, go to W_IDLE and reassert awready next cycle.
  - Minimum write turnaround: AW accept cycle N, single beat at N+1, bvalid at N+2.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On arvalid&arready, capture fields, compute err with the same rules as write, and load rdata from mem[idx] into the output register.
  - R_DATA: rvalid=1 at N+1 after AR accept at N; rid=captured id, rresp=err?10:00, rlast=(beat_cnt==len).
  - rdata on error: rdata=0 when err.
  - Beat advance: on rvalid&rready, if rlast go to R_IDLE; else advance addr (same rule as write), increment beat_cnt, and register the next word.
  - Back-to-back beats: one beat per cycle under continuous rready. Outputs hold stable while rready=0.
- Simultaneous events:
  - AW and AR accepted in the same cycle: both are accepted.
  - Read fetch and write to the same word in the same cycle: the read returns the pre-write data.
  - No 4 KB boundary check.
- Reset mid-burst: outputs return to 0 immediately. A partially written burst keeps the beats already written.

Test Plan:
- Single write then read: AW addr 0x40, len 0, size 3, wdata 0x1122334455667788, wstrb 0xFF, id 5 -> bresp 00, bid 5. AR addr 0x40 id 2 -> rvalid next cycle, rdata 0x1122334455667788, rlast 1, rid 2.
- INCR burst with strobes: 4-beat write at 0x100 with data k=0..3 and beat 2 wstrb 0x0F over a preload of all-ones. Read back 4 beats -> beat 2 = 0xFFFFFFFF_00000002; rlast only on beat 3.
- Read backpressure: 4-beat read with rready toggling 1,0,0,1,1,0,1 -> data, rid and rlast stable while stalled; exactly 4 beats delivered.
- Unsupported burst: AW burst 10 with 2 beats -> no memory change, bresp 10. AR burst 10 -> rresp 10 on every beat, rdata 0.
- wlast mismatch: len 1 with wlast on beat 0 -> FSM still takes 2 beats; bresp 10.
- Reset mid-burst: drop rst_l during beat 2 of a 4-beat read -> rvalid=0 immediately. arready=0 until the first edge after release, then 1. A new read succeeds.
